// File: rtl/img_pkg.sv
// Shared constants and state encoding for the image loader.
package img_pkg;
    localparam int IMG_W      = 160;
    localparam int IMG_H      = 380;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 19;
    localparam int PIX_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_LOAD
    } state_e;
endpackage

// File: rtl/img_loader_if.sv
// Pixel stream in, frame-buffer write port out.
interface img_loader_if #(
    parameter int PIX_W  = img_pkg::PIX_W,
    parameter int ADDR_W = img_pkg::ADDR_W
);
    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic [PIX_W-1:0]  s_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (
        output s_valid, s_sof, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  s_valid, s_sof, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/img_addr_gen.sv
// Column/row/linear-address counters; the linear address is kept incrementally.
module img_addr_gen #(
    parameter int IMG_W  = img_pkg::IMG_W,
    parameter int IMG_H  = img_pkg::IMG_H,
    parameter int ADDR_W = img_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic              restart_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (restart_i) begin
            // the start-of-frame beat itself occupies address 0
            col_d  = CW'(1);
            row_d  = '0;
            addr_d = ADDR_W'(1);
        end else if (adv_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
endmodule

// File: rtl/img_loader.sv
// Loads one frame from a pixel stream into an external frame buffer, gated by wr_allow.
module img_loader #(
    parameter int IMG_W = img_pkg::IMG_W,
    parameter int IMG_H = img_pkg::IMG_H
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         wr_allow,
    img_loader_if.slave  bus,
    output logic         busy,
    output logic         frame_done,
    output logic         sof_err
);
    import img_pkg::*;

    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ag_adv, ag_restart, ag_clear, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic              accept;

    assign bus.s_ready = (state_q != ST_IDLE) & wr_allow;
    assign accept      = bus.s_valid & bus.s_ready;

    img_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv_i     (ag_adv),
        .restart_i (ag_restart),
        .clear_i   (ag_clear),
        .addr_o    (ag_addr),
        .last_o    (ag_last)
    );

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ag_adv     = 1'b0;
        ag_restart = 1'b0;
        ag_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_SOF;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT_SOF: begin
                if (accept && bus.s_sof) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = bus.s_data;
                    ag_restart = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus.s_data;
                    // a stray SOF resynchronises rather than aborting the frame
                    if (bus.s_sof) begin
                        wr_addr_d  = '0;
                        ag_restart = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        wr_addr_d = ag_addr;
                        if (ag_last) begin
                            ag_clear = 1'b1;
                            done_d   = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            ag_adv = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign sof_err     = err_q;
endmodule

// File: tb/tb_img_loader.sv
// Scoreboard bench for img_loader on a reduced 20x12 frame.
module tb_img_loader;
    localparam int W = 20;
    localparam int H = 12;
    localparam int P = W * H;

    typedef struct {
        logic [18:0] addr;
        logic [11:0] data;
        logic        last;
    } exp_t;
    typedef enum {M_IDLE, M_WAIT, M_LOAD} mst_e;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_allow = 1'b0;
    logic busy, frame_done, sof_err;

    img_loader_if bus ();

    img_loader #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .wr_allow   (wr_allow),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_fail = 0;
    int   done_cnt = 0, wr_cnt = 0;
    logic [18:0] last_addr = '0;
    logic [11:0] last_data = '0;
    bit   mon_on = 0, toggle_on = 0;
    int   ph = 0;

    mst_e m_st = M_IDLE;
    int   m_pos = 0;
    logic m_err = 1'b0;
    exp_t sb[$];
    exp_t e;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
    end

    // reference model: evaluates the same edge the DUT samples
    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_pos = 0; m_err = 1'b0;
        end else if (m_st == M_IDLE) begin
            if (start) begin m_st = M_WAIT; m_err = 1'b0; end
        end else if (bus.s_valid && wr_allow) begin
            if (bus.s_sof) begin
                sb.push_back('{19'd0, bus.s_data, 1'b0});
                if (m_st == M_LOAD) m_err = 1'b1;
                m_st = M_LOAD; m_pos = 1;
            end else if (m_st == M_LOAD) begin
                sb.push_back('{19'(m_pos), bus.s_data, (m_pos == P - 1)});
                if (m_pos == P - 1) begin m_pos = 0; m_st = M_IDLE; end
                else m_pos++;
            end
        end
    end

    always @(negedge clk) if (mon_on) begin
        n_chk++;
        if (busy !== (m_st != M_IDLE)) begin n_fail++; $display("FAIL busy: got %b exp %b", busy, m_st != M_IDLE); end
        n_chk++;
        if (sof_err !== m_err) begin n_fail++; $display("FAIL sof_err: got %b exp %b", sof_err, m_err); end
        n_chk++;
        if (bus.s_ready !== ((m_st != M_IDLE) && wr_allow)) begin
            n_fail++; $display("FAIL s_ready: got %b exp %b", bus.s_ready, (m_st != M_IDLE) && wr_allow);
        end
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL unexpected_write: got addr %0d exp no write", bus.wr_addr);
            end else begin
                e = sb.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data || frame_done !== e.last) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %h done %b exp addr %0d data %h done %b",
                             bus.wr_addr, bus.wr_data, frame_done, e.addr, e.data, e.last);
                end
            end
        end else begin
            n_chk++;
            if (bus.wr_en !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++; $display("FAIL idle_strobes: got wr_en %b done %b exp 0 0", bus.wr_en, frame_done);
            end
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    always begin
        @(posedge clk); #1;
        if (toggle_on) begin ph = (ph + 1) % 7; wr_allow = (ph < 4); end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic send(input logic sof, input logic [11:0] d, input bit rnd, input bit st = 0);
        bit acc = 0;
        int t = 0;
        if (rnd) repeat ($urandom_range(0, 2)) cyc(1);
        bus.s_valid = 1'b1; bus.s_sof = sof; bus.s_data = d; start = st;
        while (!acc) begin
            @(negedge clk); acc = (bus.s_ready === 1'b1);
            @(posedge clk); #1; start = 1'b0; t++;
            if (!acc && t > 200) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: got no accept exp accept");
                break;
            end
        end
        bus.s_valid = 1'b0; bus.s_sof = 1'b0;
    endtask

    task automatic send_run(input int first, input int n, input bit sof_first, input bit rnd);
        for (int i = 0; i < n; i++) send(sof_first && i == 0, 12'(first + i), rnd);
    endtask

    task automatic check_zero(input string nm);
        n_chk++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, sof_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL %s: got en %b addr %0d data %h done %b err %b busy %b exp all 0",
                     nm, bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, sof_err, busy);
        end
    endtask

    task automatic test_reset();
        wr_allow = 1'b1; rst_n = 1'b0;
        cyc(2);
        mon_on = 1;
        check_zero("reset_outputs");
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_full_frame();
        int d0 = done_cnt, w0 = wr_cnt;
        pulse_start();
        send_run(0, P, 1, 0);
        cyc(3);
        n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL full_done: got %0d exp %0d", done_cnt - d0, 1); end
        n_chk++; if (wr_cnt !== w0 + P) begin n_fail++; $display("FAIL full_writes: got %0d exp %0d", wr_cnt - w0, P); end
        n_chk++; if (last_addr !== 19'(P - 1)) begin n_fail++; $display("FAIL full_last: got %0d exp %0d", last_addr, P - 1); end
        n_chk++; if (busy !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL full_idle: got busy %b pend %0d exp 0 0", busy, sb.size()); end
    endtask

    task automatic test_wait_sof();
        int d0 = done_cnt, w0 = wr_cnt;
        pulse_start();
        for (int k = 0; k < 3; k++) send(1'b0, 12'(12'hE00 + k), 0);
        cyc(2);
        n_chk++; if (wr_cnt !== w0 || busy !== 1'b1) begin n_fail++; $display("FAIL presof: got writes %0d busy %b exp 0 1", wr_cnt - w0, busy); end
        send(1'b1, 12'h5A5, 0);
        cyc(1);
        n_chk++; if (last_addr !== 19'd0 || last_data !== 12'h5A5) begin
            n_fail++; $display("FAIL sof_write: got addr %0d data %h exp 0 5a5", last_addr, last_data);
        end
        send_run(12'h300, P - 1, 0, 0);
        cyc(3);
        n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL wait_done: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_sof_err();
        int d0 = done_cnt;
        pulse_start();
        send_run(0, 50, 1, 0);
        n_chk++; if (sof_err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b exp 0", sof_err); end
        send(1'b1, 12'hABC, 0);
        cyc(1);
        n_chk++; if (sof_err !== 1'b1 || last_addr !== 19'd0 || last_data !== 12'hABC) begin
            n_fail++; $display("FAIL resync: got err %b addr %0d data %h exp 1 0 abc", sof_err, last_addr, last_data);
        end
        send_run(12'h700, P - 2, 0, 0);
        cyc(2);
        n_chk++; if (done_cnt !== d0 || busy !== 1'b1) begin n_fail++; $display("FAIL resync_early: got done %0d busy %b exp 0 1", done_cnt - d0, busy); end
        send(1'b0, 12'hFFF, 0);
        cyc(2);
        n_chk++; if (done_cnt !== d0 + 1 || last_addr !== 19'(P - 1)) begin
            n_fail++; $display("FAIL resync_done: got done %0d addr %0d exp 1 %0d", done_cnt - d0, last_addr, P - 1);
        end
        n_chk++; if (sof_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", sof_err); end
    endtask

    task automatic test_stall();
        int d0 = done_cnt, w0 = wr_cnt;
        toggle_on = 1;
        pulse_start();
        send_run(0, P, 1, 1);
        cyc(3);
        toggle_on = 0; wr_allow = 1'b1;
        n_chk++; if (done_cnt !== d0 + 1 || wr_cnt !== w0 + P) begin
            n_fail++; $display("FAIL stall_count: got done %0d writes %0d exp 1 %0d", done_cnt - d0, wr_cnt - w0, P);
        end
        n_chk++; if (last_addr !== 19'(P - 1) || sof_err !== 1'b0) begin
            n_fail++; $display("FAIL stall_last: got addr %0d err %b exp %0d 0", last_addr, sof_err, P - 1);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        pulse_start();
        send_run(0, 100, 1, 0);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check_zero("midreset_outputs");
        cyc(5);
        n_chk++; if (done_cnt !== d0 || wr_cnt < 100) begin n_fail++; $display("FAIL midreset_done: got %0d exp 0", done_cnt - d0); end
        pulse_start();
        send(1'b1, 12'h0C3, 0);
        cyc(1);
        n_chk++; if (last_addr !== 19'd0 || last_data !== 12'h0C3) begin
            n_fail++; $display("FAIL reload_first: got addr %0d data %h exp 0 0c3", last_addr, last_data);
        end
        send_run(1, P - 1, 0, 0);
        cyc(3);
        n_chk++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL reload_done: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_start_ignored();
        int d0 = done_cnt;
        pulse_start();
        send_run(0, 10, 1, 0);
        pulse_start();
        send_run(10, P - 11, 0, 0);
        send(1'b0, 12'h123, 0, 1);
        cyc(3);
        n_chk++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL start_ign: got done %0d busy %b exp 1 0", done_cnt - d0, busy);
        end
        cyc(4);
        n_chk++; if (busy !== 1'b0 || bus.s_ready !== 1'b0 || done_cnt !== d0 + 1) begin
            n_fail++; $display("FAIL start_ign_idle: got busy %b ready %b done %0d exp 0 0 1", busy, bus.s_ready, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_wait_sof();
        test_sof_err();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
